// File: rtl/lcd_16207_bus_master.sv
// Self-timed HD44780 (16207) LCD bus master: one request at a time on a
// valid/ready port, spaced RS/RW/E cycles, optional busy-flag polling after writes.
module lcd_16207_bus_master #(
  parameter int T_AS      = 2,
  parameter int T_PW      = 12,
  parameter int T_H       = 2,
  parameter int T_GAP     = 10,
  parameter bit POLL_BUSY = 1'b1,
  parameter int MAX_POLLS = 4096
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rs,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       timeout_err,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  inout  wire  [7:0] LCD_data
);

  localparam int T_MAX_A = (T_AS > T_PW) ? T_AS : T_PW;
  localparam int T_MAX_B = (T_H > T_GAP) ? T_H : T_GAP;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int CNT_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int PCNT_W  = $clog2(MAX_POLLS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_RECOVER, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PCNT_W-1:0]   poll_cnt_q, poll_cnt_d;
  logic                cur_rs_q, cur_rs_d;
  logic                cur_rw_q, cur_rw_d;
  logic                req_rw_q, req_rw_d;
  logic                is_poll_q, is_poll_d;
  logic                timeout_q, timeout_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic [7:0]          capture_q, capture_d;
  logic [7:0]          rsp_data_q, rsp_data_d;
  logic                in_cycle;

  // NOTE: every signal gets its hold value first so no path through the case leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    poll_cnt_d = poll_cnt_q;
    cur_rs_d   = cur_rs_q;
    cur_rw_d   = cur_rw_q;
    req_rw_d   = req_rw_q;
    is_poll_d  = is_poll_q;
    timeout_d  = timeout_q;
    wr_data_d  = wr_data_q;
    capture_d  = capture_q;
    rsp_data_d = rsp_data_q;

    unique case (state_q)
      S_IDLE: begin
        poll_cnt_d = '0;
        timeout_d  = 1'b0;
        if (cmd_valid) begin
          state_d   = S_SETUP;
          cnt_d     = CNT_W'(T_AS - 1);
          cur_rs_d  = cmd_rs;
          cur_rw_d  = cmd_rw;
          req_rw_d  = cmd_rw;
          wr_data_d = cmd_data;
          is_poll_d = 1'b0;
        end
      end
      S_SETUP: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = S_PULSE;
          cnt_d   = CNT_W'(T_PW - 1);
        end
      end
      S_PULSE: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          // Sample the LCD while E is still high, just before it falls.
          if (cur_rw_q) capture_d = LCD_data;
          state_d = S_HOLD;
          cnt_d   = CNT_W'(T_H - 1);
        end
      end
      S_HOLD: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = S_RECOVER;
          cnt_d   = CNT_W'(T_GAP - 1);
        end
      end
      S_RECOVER: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          if (!is_poll_q && (req_rw_q || !POLL_BUSY)) begin
            state_d = S_DONE;
            // A write without polling leaves the previous response byte in place.
            if (req_rw_q) rsp_data_d = capture_q;
          end else if (is_poll_q && (!capture_q[7] || poll_cnt_q == PCNT_W'(MAX_POLLS))) begin
            state_d    = S_DONE;
            rsp_data_d = capture_q;
            timeout_d  = capture_q[7];
          end else begin
            state_d    = S_SETUP;
            cnt_d      = CNT_W'(T_AS - 1);
            cur_rs_d   = 1'b0;
            cur_rw_d   = 1'b1;
            is_poll_d  = 1'b1;
            poll_cnt_d = poll_cnt_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers update with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      poll_cnt_q <= '0;
      cur_rs_q   <= 1'b0;
      cur_rw_q   <= 1'b1;
      req_rw_q   <= 1'b1;
      is_poll_q  <= 1'b0;
      timeout_q  <= 1'b0;
      wr_data_q  <= '0;
      capture_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      poll_cnt_q <= poll_cnt_d;
      cur_rs_q   <= cur_rs_d;
      cur_rw_q   <= cur_rw_d;
      req_rw_q   <= req_rw_d;
      is_poll_q  <= is_poll_d;
      timeout_q  <= timeout_d;
      wr_data_q  <= wr_data_d;
      capture_q  <= capture_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign in_cycle    = (state_q == S_SETUP) || (state_q == S_PULSE) || (state_q == S_HOLD);
  assign cmd_ready   = (state_q == S_IDLE);
  assign rsp_valid   = (state_q == S_DONE);
  assign timeout_err = rsp_valid && timeout_q;
  assign rsp_data    = rsp_data_q;
  assign LCD_E       = (state_q == S_PULSE);
  assign LCD_RW      = in_cycle ? cur_rw_q : 1'b1;
  assign LCD_RS      = (in_cycle || state_q == S_RECOVER) ? cur_rs_q : 1'b0;
  // The bus is only ever driven while RW is low, so the LCD and this block never fight.
  assign LCD_data    = (in_cycle && !cur_rw_q) ? wr_data_q : 8'hzz;

endmodule

// File: tb/tb_lcd_16207_bus_master.sv
// Directed bench for lcd_16207_bus_master: two instances (no polling / polling with
// MAX_POLLS=3) against a small LCD model, with a response scoreboard.
module tb_lcd_16207_bus_master;

  localparam int B = 26;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       to;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       v_np = 1'b0, v_p = 1'b0;
  logic       cmd_rs = 1'b0, cmd_rw = 1'b1;
  logic [7:0] cmd_data = 8'h00;

  logic       rdy_np, rv_np, to_np, e_np, rs_np, rw_np;
  logic       rdy_p, rv_p, to_p, e_p, rs_p, rw_p;
  logic [7:0] rd_np, rd_p;
  wire  [7:0] d_np, d_p;

  lcd_16207_bus_master #(.POLL_BUSY(1'b0)) u_np (
    .clk(clk), .reset_n(reset_n), .cmd_valid(v_np), .cmd_ready(rdy_np),
    .cmd_rs(cmd_rs), .cmd_rw(cmd_rw), .cmd_data(cmd_data),
    .rsp_valid(rv_np), .rsp_data(rd_np), .timeout_err(to_np),
    .LCD_E(e_np), .LCD_RS(rs_np), .LCD_RW(rw_np), .LCD_data(d_np)
  );

  lcd_16207_bus_master #(.POLL_BUSY(1'b1), .MAX_POLLS(3)) u_p (
    .clk(clk), .reset_n(reset_n), .cmd_valid(v_p), .cmd_ready(rdy_p),
    .cmd_rs(cmd_rs), .cmd_rw(cmd_rw), .cmd_data(cmd_data),
    .rsp_valid(rv_p), .rsp_data(rd_p), .timeout_err(to_p),
    .LCD_E(e_p), .LCD_RS(rs_p), .LCD_RW(rw_p), .LCD_data(d_p)
  );

  // LCD models: drive the bus only while E is high with RW=1.
  logic [7:0] np_status = 8'h27;
  logic [7:0] reply_tab [8];
  int         e_cnt_p = 0;
  int         base_p = 0;
  int         k_p;
  logic [7:0] p_val;

  always @(negedge e_p) if (rw_p) e_cnt_p <= e_cnt_p + 1;

  always_comb begin
    p_val = 8'h80;
    k_p   = e_cnt_p - base_p;
    if (k_p >= 0 && k_p < 8) p_val = reply_tab[k_p[2:0]];
  end

  assign d_np = (e_np && rw_np) ? np_status : 8'hzz;
  assign d_p  = (e_p && rw_p) ? p_val : 8'hzz;

  logic       sel = 1'b0;
  logic       m_rdy, m_rv, m_to, m_e, m_rs, m_rw;
  logic [7:0] m_rd, m_d, m_model;
  assign m_rdy   = sel ? rdy_p : rdy_np;
  assign m_rv    = sel ? rv_p  : rv_np;
  assign m_to    = sel ? to_p  : to_np;
  assign m_e     = sel ? e_p   : e_np;
  assign m_rs    = sel ? rs_p  : rs_np;
  assign m_rw    = sel ? rw_p  : rw_np;
  assign m_rd    = sel ? rd_p  : rd_np;
  assign m_d     = sel ? d_p   : d_np;
  assign m_model = sel ? p_val : np_status;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  int         acc, e_rise, e_fall, rsp_cyc, rdy_cyc, rsp_pulses, to_pulses;
  int         hold_bad, bus_bad, polls;
  logic [7:0] rsp_d;
  logic       rsp_to;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // An undriven bus reads Z in a 4-state simulator and 0 in a 2-state one.
  function automatic bit floating(input logic [7:0] v);
    return (v === 8'hzz) || (v === 8'h00);
  endfunction

  task automatic do_req(input bit s, input logic rs, input logic rw,
                        input logic [7:0] data, input int limit);
    int  w;
    bit  prev_e;
    sel = s;
    w = 0;
    while (!m_rdy && w < 100) begin
      @(negedge clk);
      w++;
    end
    cmd_rs = rs; cmd_rw = rw; cmd_data = data;
    if (s) v_p = 1'b1; else v_np = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    v_p = 1'b0; v_np = 1'b0;
    e_rise = -1; e_fall = -1; rsp_cyc = -1; rdy_cyc = -1;
    rsp_pulses = 0; to_pulses = 0; hold_bad = 0; bus_bad = 0; polls = 0;
    rsp_d = 8'h00; rsp_to = 1'b0; prev_e = 1'b0;
    for (int j = 1; j <= limit; j++) begin
      @(negedge clk);
      if (m_e && e_rise < 0) e_rise = j;
      if (!m_e && e_rise >= 0 && e_fall < 0) e_fall = j;
      if (m_e && !prev_e && j > 16 && m_rs === 1'b0 && m_rw === 1'b1) polls++;
      prev_e = m_e;
      if (j <= 16 && !(m_rs === rs && m_rw === rw && (rw || m_d === data))) hold_bad++;
      if (m_rw === 1'b1) begin
        if (m_e) begin
          if (m_d !== m_model) bus_bad++;
        end else if (!floating(m_d)) bus_bad++;
      end
      if (m_to) to_pulses++;
      if (m_rv) begin
        rsp_pulses++;
        if (rsp_cyc < 0) begin
          rsp_cyc = j; rsp_d = m_rd; rsp_to = m_to;
        end
      end
      if (rsp_cyc >= 0 && j > rsp_cyc && m_rdy && rdy_cyc < 0) rdy_cyc = j;
      if (rdy_cyc >= 0) break;
    end
  endtask

  task automatic check_rsp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_rsp_cycle"}, rsp_cyc, e.cyc);
    check({tag, "_rsp_data"}, rsp_d, e.data);
    check({tag, "_timeout"}, rsp_to, e.to);
    check({tag, "_rsp_pulses"}, rsp_pulses, 1);
    check({tag, "_ready_back"}, rdy_cyc, e.cyc + 1);
  endtask

  initial begin
    int first_acc, first_rise, n_rv;
    bit saw_e;

    // Reset held with requests pending on both instances.
    reset_n = 1'b0; v_np = 1'b1; v_p = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_E", {e_np, e_p}, 2'b00);
    check("rst_RW", {rw_np, rw_p}, 2'b11);
    check("rst_RS", {rs_np, rs_p}, 2'b00);
    check("rst_rsp", {rv_np, rv_p, to_np, to_p}, 4'b0000);
    check("rst_bus_float", {31'd0, floating(d_np) && floating(d_p)}, 32'd1);
    v_np = 1'b0; v_p = 1'b0;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rel_ready", {rdy_np, rdy_p}, 2'b11);
    check("rel_idle", {e_np, e_p, rw_np, rw_p}, 4'b0011);
    check("rel_rsp_data", {rd_np, rd_p}, 16'h0000);

    // Data write 0x41, no polling: response byte stays at its reset value.
    sb.push_back('{cyc: 1 + B, data: 8'h00, to: 1'b0});
    do_req(1'b0, 1'b1, 1'b0, 8'h41, 60);
    check("wr_e_rise", e_rise, 3);
    check("wr_e_fall", e_fall, 15);
    check("wr_pins_hold", hold_bad, 0);
    check("wr_bus", bus_bad, 0);
    check_rsp("wr");
    first_acc  = acc;
    first_rise = e_rise;

    // Status read back-to-back.
    np_status = 8'h27;
    sb.push_back('{cyc: 1 + B, data: 8'h27, to: 1'b0});
    do_req(1'b0, 1'b0, 1'b1, 8'hC0, 60);
    check("rd_e_rise", e_rise, 3);
    check("rd_e_fall", e_fall, 15);
    check("rd_no_drive", bus_bad, 0);
    check("b2b_spacing_ok", {31'd0, (acc + e_rise) - (first_acc + first_rise) >= B + 2}, 32'd1);
    check_rsp("rd");

    // Instruction write with polling: busy, busy, then ready.
    reply_tab[0] = 8'h80; reply_tab[1] = 8'h80; reply_tab[2] = 8'h03;
    for (int i = 3; i < 8; i++) reply_tab[i] = 8'h00;
    base_p = e_cnt_p;
    sb.push_back('{cyc: 1 + 4 * B, data: 8'h03, to: 1'b0});
    do_req(1'b1, 1'b0, 1'b0, 8'h01, 140);
    check("poll_count", polls, 3);
    check("poll_pins_hold", hold_bad, 0);
    check("poll_bus", bus_bad, 0);
    check_rsp("poll");

    // Busy never clears: timeout after MAX_POLLS=3 polls.
    for (int i = 0; i < 8; i++) reply_tab[i] = 8'h80;
    base_p = e_cnt_p;
    sb.push_back('{cyc: 1 + 4 * B, data: 8'h80, to: 1'b1});
    do_req(1'b1, 1'b1, 1'b0, 8'h55, 140);
    check("to_poll_count", polls, 3);
    check("to_pulse_count", to_pulses, 1);
    check("to_bus", bus_bad, 0);
    check_rsp("to");

    // Abort during the E pulse.
    sel = 1'b0;
    @(negedge clk);
    cmd_rs = 1'b1; cmd_rw = 1'b0; cmd_data = 8'h3C; v_np = 1'b1;
    @(posedge clk);
    #1;
    v_np = 1'b0;
    saw_e = 1'b0;
    for (int j = 0; j < 10 && !saw_e; j++) begin
      @(negedge clk);
      saw_e = e_np;
    end
    check("abort_in_pulse", {31'd0, saw_e}, 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_E_low", e_np, 1'b0);
    check("abort_bus_float", {31'd0, floating(d_np)}, 32'd1);
    check("abort_RW", rw_np, 1'b1);
    n_rv = 0;
    repeat (2) begin
      @(negedge clk);
      if (rv_np) n_rv++;
    end
    reset_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (rv_np) n_rv++;
    end
    check("abort_no_rsp", n_rv, 0);

    np_status = 8'h27;
    sb.push_back('{cyc: 1 + B, data: 8'h27, to: 1'b0});
    do_req(1'b0, 1'b0, 1'b1, 8'hC0, 60);
    check("post_abort_e_rise", e_rise, 3);
    check_rsp("post_abort");

    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
